// File: rtl/am2910_seq_ctrl_if.sv
// Command/status link between the sequencer control and its return-address stack.
// Master side issues push/pop/clear with push data; slave side returns top and status.
interface am2910_seq_ctrl_if #(parameter int AW = 12);
  logic          stk_push;
  logic          stk_pop;
  logic          stk_clear;
  logic [AW-1:0] stk_din;
  logic [AW-1:0] stk_top;
  logic          stk_full;
  logic          stk_empty;

  modport master (
    output stk_push, stk_pop, stk_clear, stk_din,
    input  stk_top, stk_full, stk_empty
  );

  modport slave (
    input  stk_push, stk_pop, stk_clear, stk_din,
    output stk_top, stk_full, stk_empty
  );
endinterface

// File: rtl/am2910_seq_ctrl.sv
// AM2910-style next-address control: instruction decode, Y select, uPC and R.
// Stack commands are combinational and take effect at the same edge as uPC/R.
module am2910_seq_ctrl #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    instr,
  input  logic          cc_n,
  input  logic          ccen_n,
  input  logic          ci,
  input  logic          rld_n,
  input  logic [AW-1:0] d,
  output logic [AW-1:0] y,
  output logic          pl_n,
  output logic          map_n,
  output logic          vect_n,
  output logic          full_n,
  am2910_seq_ctrl_if.master stk
);

  typedef enum logic [3:0] {
    JZ   = 4'd0,  CJS  = 4'd1,  JMAP = 4'd2,  CJP  = 4'd3,
    PUSH = 4'd4,  JSRP = 4'd5,  CJV  = 4'd6,  JRP  = 4'd7,
    RFCT = 4'd8,  RPCT = 4'd9,  CRTN = 4'd10, CJPP = 4'd11,
    LDCT = 4'd12, LOOP = 4'd13, CONT = 4'd14, TWB  = 4'd15
  } op_e;

  logic [AW-1:0] upc, r, r_nxt;
  logic          pass, rz, push, pop, clr;
  op_e           op;

  assign op   = op_e'(instr);
  assign pass = ccen_n | ~cc_n;
  assign rz   = (r == '0);

  always_comb begin
    y     = upc;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    r_nxt = r;
    case (op)
      JZ:   begin y = '0; clr = 1'b1; end
      CJS:  if (pass) begin y = d; push = 1'b1; end
      JMAP: y = d;
      CJP:  if (pass) y = d;
      PUSH: begin push = 1'b1; if (pass) r_nxt = d; end
      JSRP: begin y = pass ? d : r; push = 1'b1; end
      CJV:  if (pass) y = d;
      JRP:  y = pass ? d : r;
      RFCT: if (!rz) begin y = stk.stk_top; r_nxt = r - 1'b1; end
            else pop = 1'b1;
      RPCT: if (!rz) begin y = d; r_nxt = r - 1'b1; end
      CRTN: if (pass) begin y = stk.stk_top; pop = 1'b1; end
      CJPP: if (pass) begin y = d; pop = 1'b1; end
      LDCT: r_nxt = d;
      LOOP: if (pass) pop = 1'b1;
            else y = stk.stk_top;
      CONT: ;
      TWB: begin
        // Counter expiry or pass both exit the loop; only fail with count left loops back.
        if (!rz) begin
          r_nxt = r - 1'b1;
          if (pass) pop = 1'b1;
          else      y = stk.stk_top;
        end else begin
          pop = 1'b1;
          if (!pass) y = d;
        end
      end
      default: ;
    endcase
    if (!rld_n) r_nxt = d;
  end

  assign pl_n   = (op == JMAP) || (op == CJV);
  assign map_n  = (op != JMAP);
  assign vect_n = (op != CJV);
  assign full_n = ~stk.stk_full;

  assign stk.stk_push  = push;
  assign stk.stk_pop   = pop;
  assign stk.stk_clear = clr;
  assign stk.stk_din   = upc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upc <= '0;
      r   <= '0;
    end else begin
      upc <= y + AW'(ci);
      r   <= r_nxt;
    end
  end

endmodule

// File: tb/tb_am2910_seq_ctrl.sv
// Scoreboard bench for am2910_seq_ctrl with a behavioural 5-deep stack attached.
module tb_am2910_seq_ctrl;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    instr;
  logic          cc_n, ccen_n, ci, rld_n;
  logic [AW-1:0] d, y;
  logic          pl_n, map_n, vect_n, full_n;

  am2910_seq_ctrl_if #(.AW(AW)) stk ();

  am2910_seq_ctrl #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .instr(instr), .cc_n(cc_n), .ccen_n(ccen_n),
    .ci(ci), .rld_n(rld_n), .d(d), .y(y), .pl_n(pl_n), .map_n(map_n),
    .vect_n(vect_n), .full_n(full_n), .stk(stk)
  );

  always #5 clk = ~clk;

  // attached return-address stack
  logic [AW-1:0] hmem [5];
  logic [2:0]    hdepth;
  assign stk.stk_top   = (hdepth != 3'd0) ? hmem[hdepth - 3'd1] : '0;
  assign stk.stk_full  = (hdepth == 3'd5);
  assign stk.stk_empty = (hdepth == 3'd0);

  always @(posedge clk or posedge reset) begin
    if (reset) hdepth <= 3'd0;
    else if (stk.stk_clear) hdepth <= 3'd0;
    else if (stk.stk_push && hdepth < 3'd5) begin
      hmem[hdepth] <= stk.stk_din;
      hdepth <= hdepth + 3'd1;
    end else if (stk.stk_pop && hdepth != 3'd0) hdepth <= hdepth - 3'd1;
  end

  typedef struct {
    logic [AW-1:0] y;
    logic          push, pop, clr, full_n;
    logic [AW-1:0] din;
    logic [2:0]    src;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] mupc, mr;
  logic [AW-1:0] mq[$];
  int            ncmp = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mupc = '0; mr = '0; mq.delete();
  endtask

  // Drive one instruction, score it mid-cycle, then advance the model on the edge.
  task automatic step(input logic [3:0] i, input logic pass_in, input logic c,
                      input logic rl, input logic [AW-1:0] dv);
    exp_t e;
    logic pass, rz;
    logic [AW-1:0] top, nr;
    exp_t got;
    instr = i; ccen_n = 1'b0; cc_n = ~pass_in; ci = c; rld_n = rl; d = dv;
    pass = pass_in; rz = (mr == 0);
    top = (mq.size() > 0) ? mq[mq.size()-1] : '0;
    e.y = mupc; e.push = 0; e.pop = 0; e.clr = 0; nr = mr;
    case (i)
      0:  begin e.y = 0; e.clr = 1; end
      1:  if (pass) begin e.y = dv; e.push = 1; end
      2:  e.y = dv;
      3:  if (pass) e.y = dv;
      4:  begin e.push = 1; if (pass) nr = dv; end
      5:  begin e.y = pass ? dv : mr; e.push = 1; end
      6:  if (pass) e.y = dv;
      7:  e.y = pass ? dv : mr;
      8:  if (!rz) begin e.y = top; nr = mr - 1; end else e.pop = 1;
      9:  if (!rz) begin e.y = dv; nr = mr - 1; end
      10: if (pass) begin e.y = top; e.pop = 1; end
      11: if (pass) begin e.y = dv; e.pop = 1; end
      12: nr = dv;
      13: if (pass) e.pop = 1; else e.y = top;
      14: ;
      15: if (!rz) begin nr = mr - 1; if (pass) e.pop = 1; else e.y = top; end
          else begin e.pop = 1; if (!pass) e.y = dv; end
    endcase
    if (!rl) nr = dv;
    e.din = mupc;
    e.src = (i == 2) ? 3'b101 : (i == 6) ? 3'b110 : 3'b011;
    e.full_n = (mq.size() == 5) ? 1'b0 : 1'b1;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    chk("y", y, got.y);
    chk("cmd", {stk.stk_push, stk.stk_pop, stk.stk_clear}, {got.push, got.pop, got.clr});
    if (got.push) chk("din", stk.stk_din, got.din);
    chk("src", {pl_n, map_n, vect_n}, got.src);
    chk("full_n", full_n, got.full_n);
    @(posedge clk);
    mupc = e.y + AW'(c);
    mr = nr;
    if (e.clr) mq.delete();
    else if (e.push) begin if (mq.size() < 5) mq.push_back(e.din); end
    else if (e.pop && mq.size() > 0) void'(mq.pop_back());
    #1;
  endtask

  initial begin
    reset = 1'b1; instr = 4'd14; cc_n = 1'b1; ccen_n = 1'b1; ci = 1'b0;
    rld_n = 1'b1; d = '0;
    model_reset();
    #12;
    chk("reset_y", y, 0);
    chk("reset_cmd", {stk.stk_push, stk.stk_pop, stk.stk_clear}, 3'b000);
    @(posedge clk); #1 reset = 1'b0;

    for (int k = 0; k < 4; k++) step(14, 1, 1, 1, '0);       // y = 0,1,2,3
    step(3, 1, 1, 1, 12'h00F);                               // upc -> 0x010
    step(1, 1, 1, 1, 12'h200);                               // CJS: push 0x010
    step(10, 1, 1, 1, '0);                                   // CRTN -> 0x010
    step(3, 0, 1, 1, 12'h777);                               // CJP fail
    step(12, 1, 1, 1, 12'd3);                                // LDCT 3
    for (int k = 0; k < 4; k++) step(9, 1, 1, 1, 12'h050);   // RPCT x3 then fall through
    for (int k = 0; k < 6; k++) step(1, 1, 1, 1, 12'h300 + 12'(k)); // fill and overfill
    chk("depth_full", hdepth, 5);
    for (int k = 0; k < 6; k++) step(10, 1, 0, 1, '0);       // unwind, last on empty
    chk("depth_empty", hdepth, 0);
    step(1, 1, 1, 1, 12'h100);
    step(12, 1, 1, 1, 12'd5);
    step(8, 1, 1, 0, 12'h0AB);                               // RFCT with R load
    step(7, 0, 1, 1, '0);                                    // JRP fail exposes R
    step(0, 1, 1, 1, '0);                                    // JZ
    step(13, 0, 1, 1, '0);
    step(2, 1, 0, 1, 12'h3FF);
    step(6, 1, 0, 1, 12'h155);
    step(6, 0, 1, 1, 12'h155);
    step(12, 1, 1, 1, 12'd2);
    for (int k = 0; k < 4; k++) step(15, 0, 1, 1, 12'h0C0);  // TWB count down
    for (int k = 0; k < 60; k++)
      step(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 7) != 0), 12'($urandom));

    // asynchronous reset in the middle of a cycle
    step(12, 1, 1, 1, 12'h044);
    instr = 4'd7; ccen_n = 1'b0; cc_n = 1'b1; ci = 1'b0; rld_n = 1'b1;
    #2 reset = 1'b1;
    #1 chk("midreset_y", y, 0);
    model_reset();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    step(7, 0, 0, 1, '0);                                    // R is 0 after reset
    step(10, 1, 1, 1, '0);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end
endmodule
